// File: rtl/axi_pkg.sv
// Shared AXI constants and the line-fill FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } t_fill_state;

  // Counter width that stays legal for a single-beat line.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/line_deserializer.sv
// Packs incoming beats into a line register, slice index from a saturating counter.
// Latency: a beat presented with i_beat_vld lands in o_line on the next edge.
// Backpressure: none; every valid beat is consumed, beats after the last slot are dropped.
module line_deserializer
  import axi_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = 512,
  parameter int BEATS   = BLOCK_W / DATA_W,
  parameter int CNT_W   = cnt_width(BLOCK_W / DATA_W)
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               i_clr,
  input  logic               i_beat_vld,
  input  logic [DATA_W-1:0]  i_beat_dat,
  output logic [BLOCK_W-1:0] o_line,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_full
);

  logic [BLOCK_W-1:0] line_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               full_q;
  logic [BEATS-1:0]   slice_we;
  logic               last_slot;

  // The counter parks on the final slot; full_q remembers that slot was written.
  assign last_slot = (cnt_q == CNT_W'(BEATS - 1));

  // One write enable per slice; nothing is written once the last slot is filled.
  always_comb begin
    slice_we = '0;
    for (int k = 0; k < BEATS; k++) begin
      slice_we[k] = i_beat_vld && !full_q && (cnt_q == CNT_W'(k));
    end
  end

  // Line storage: survives across transfers, only reset clears it.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      line_q <= '0;
    end else begin
      for (int k = 0; k < BEATS; k++) begin
        if (slice_we[k]) line_q[k*DATA_W +: DATA_W] <= i_beat_dat;
      end
    end
  end

  // Saturating beat counter plus last-slot-written flag.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (i_clr) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (i_beat_vld && !full_q) begin
      if (last_slot) full_q <= 1'b1;
      else           cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign o_line = line_q;
  assign o_cnt  = cnt_q;
  assign o_full = full_q;

endmodule

// File: rtl/axi_line_fill.sv
// Refills one cache line with a single AXI INCR read burst and pulses o_done.
// Latency: BEATS+2 cycles start-to-done with a zero-wait slave, +1 per AR/R wait cycle.
// Backpressure: AR held until AR_READY; R_READY high throughout DATA, slave paces beats.
module axi_line_fill
  import axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                      clk,
  input  logic                      arstn,
  input  logic                      i_start,
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  output logic [BLOCK_WIDTH-1:0]    o_data,
  output logic                      o_done,
  output logic                      o_busy,
  output logic                      o_error,
  output logic                      AR_VALID,
  input  logic                      AR_READY,
  output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
  output logic [7:0]                AR_LEN,
  output logic [2:0]                AR_SIZE,
  output logic [1:0]                AR_BURST,
  input  logic                      R_VALID,
  output logic                      R_READY,
  input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
  input  logic [1:0]                R_RESP,
  input  logic                      R_LAST
);

  localparam int BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = cnt_width(BEATS);
  localparam int OFF_W = $clog2(BLOCK_WIDTH / 8);
  localparam logic [AXI_ADDR_WIDTH-1:0] OFF_MASK = AXI_ADDR_WIDTH'((1 << OFF_W) - 1);

  t_fill_state               state_q, state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
  logic                      err_q;
  logic                      start_acc;
  logic                      beat_hs;
  logic [CNT_W-1:0]          cnt;
  logic                      full;

  assign start_acc = (state_q == IDLE) && i_start;
  assign beat_hs   = (state_q == DATA) && R_VALID;

  // State register.
  always_ff @(posedge clk) begin
    if (!arstn) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next state and state-decoded outputs; no input reaches an output combinationally.
  always_comb begin
    state_nxt = state_q;
    AR_VALID  = 1'b0;
    R_READY   = 1'b0;
    o_done    = 1'b0;
    o_busy    = 1'b1;
    case (state_q)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = ADDR;
      end
      ADDR: begin
        AR_VALID = 1'b1;
        if (AR_READY) state_nxt = DATA;
      end
      DATA: begin
        R_READY = 1'b1;
        if (R_VALID && R_LAST) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address latch and sticky error: bad response, early R_LAST, or beat after the last slot.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      ar_addr_q <= '0;
      err_q     <= 1'b0;
    end else if (start_acc) begin
      ar_addr_q <= i_addr & ~OFF_MASK;
      err_q     <= 1'b0;
    end else if (beat_hs) begin
      err_q <= err_q
             | (R_RESP != RESP_OKAY)
             | (R_LAST && (cnt != CNT_W'(BEATS - 1)))
             | full;
    end
  end

  line_deserializer #(
    .DATA_W  (AXI_DATA_WIDTH),
    .BLOCK_W (BLOCK_WIDTH),
    .BEATS   (BEATS),
    .CNT_W   (CNT_W)
  ) u_deser (
    .clk        (clk),
    .arstn      (arstn),
    .i_clr      (start_acc),
    .i_beat_vld (beat_hs),
    .i_beat_dat (R_DATA),
    .o_line     (o_data),
    .o_cnt      (cnt),
    .o_full     (full)
  );

  assign o_error  = err_q;
  assign AR_ADDR  = ar_addr_q;
  assign AR_LEN   = 8'(BEATS - 1);
  assign AR_SIZE  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign AR_BURST = AXI_BURST_INCR;

endmodule

// File: tb/tb_axi_line_fill.sv
// Directed bench for axi_line_fill with a cycle-stepped AXI slave model.
// Latency: checks start-to-done cycle counts against hand-computed values.
// Backpressure: slave can delay AR_READY and gap R_VALID.
module tb_axi_line_fill;

  logic         clk = 1'b0;
  logic         arstn;
  logic         i_start;
  logic [63:0]  i_addr;
  logic [511:0] o_data;
  logic         o_done, o_busy, o_error;
  logic         AR_VALID, AR_READY;
  logic [63:0]  AR_ADDR;
  logic [7:0]   AR_LEN;
  logic [2:0]   AR_SIZE;
  logic [1:0]   AR_BURST;
  logic         R_VALID, R_READY;
  logic [31:0]  R_DATA;
  logic [1:0]   R_RESP;
  logic         R_LAST;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_line_fill dut (
    .clk      (clk),
    .arstn    (arstn),
    .i_start  (i_start),
    .i_addr   (i_addr),
    .o_data   (o_data),
    .o_done   (o_done),
    .o_busy   (o_busy),
    .o_error  (o_error),
    .AR_VALID (AR_VALID),
    .AR_READY (AR_READY),
    .AR_ADDR  (AR_ADDR),
    .AR_LEN   (AR_LEN),
    .AR_SIZE  (AR_SIZE),
    .AR_BURST (AR_BURST),
    .R_VALID  (R_VALID),
    .R_READY  (R_READY),
    .R_DATA   (R_DATA),
    .R_RESP   (R_RESP),
    .R_LAST   (R_LAST)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line after n beats of base+k land in slices 0..min(n,16)-1.
  function automatic logic [511:0] fill(input logic [511:0] prev, input logic [31:0] base, input int n);
    logic [511:0] r;
    r = prev;
    for (int k = 0; k < 16; k++) begin
      if (k < n) r[k*32 +: 32] = base + 32'(k);
    end
    return r;
  endfunction

  // One transfer, stepped on falling edges. cyc 0 is the start cycle.
  // Returns in the o_done cycle (done_cyc), or with arstn driven low (done_cyc=-1),
  // or after the cycle budget (done_cyc=-2).
  task automatic xfer(input logic [63:0] addr, input int ar_wait, input bit r_alt,
                      input int err_beat, input int last_beat, input int n_beats,
                      input logic [31:0] base, input bit spam, input int rst_beat,
                      output int done_cyc, output int ar_hs, output bit ar_bad);
    int  cyc, beat, arw, rcyc;
    bit  fin;
    logic [63:0] exp_addr;
    exp_addr = addr & ~64'h3F;
    cyc = 0; beat = 0; arw = 0; rcyc = 0; fin = 1'b0;
    ar_hs = 0; ar_bad = 1'b0; done_cyc = -2;
    @(negedge clk);
    i_start = 1'b1;
    i_addr  = addr;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      i_start  = spam;
      AR_READY = 1'b0;
      R_VALID  = 1'b0;
      R_LAST   = 1'b0;
      R_RESP   = 2'b00;
      if (o_done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else begin
        if (AR_VALID) begin
          if (AR_ADDR !== exp_addr) ar_bad = 1'b1;
          if (arw >= ar_wait) begin
            AR_READY = 1'b1;
            ar_hs++;
          end
          arw++;
        end
        if (R_READY) begin
          if (beat == rst_beat) begin
            arstn    = 1'b0;
            R_VALID  = 1'b1;
            R_DATA   = base + 32'(beat);
            done_cyc = -1;
            fin      = 1'b1;
          end else begin
            if ((!r_alt || (rcyc % 2 == 0)) && beat < n_beats) begin
              R_VALID = 1'b1;
              R_DATA  = base + 32'(beat);
              R_RESP  = (beat == err_beat) ? 2'b10 : 2'b00;
              R_LAST  = (beat == last_beat);
              beat++;
            end
            rcyc++;
          end
        end
      end
    end
  endtask

  initial begin
    logic [511:0] exp_line;
    int dc, hs;
    bit ab;

    arstn = 1'b0; i_start = 1'b0; i_addr = '0;
    AR_READY = 1'b0; R_VALID = 1'b0; R_DATA = '0; R_RESP = '0; R_LAST = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   512'(o_busy),   512'(0));
    chk("rst_done",   512'(o_done),   512'(0));
    chk("rst_error",  512'(o_error),  512'(0));
    chk("rst_arvld",  512'(AR_VALID), 512'(0));
    chk("rst_rrdy",   512'(R_READY),  512'(0));
    chk("rst_araddr", 512'(AR_ADDR),  512'(0));
    chk("rst_data",   o_data,         512'(0));
    chk("ar_len",     512'(AR_LEN),   512'(15));
    chk("ar_size",    512'(AR_SIZE),  512'(2));
    chk("ar_burst",   512'(AR_BURST), 512'(1));
    arstn = 1'b1;

    // Zero-wait slave, unaligned miss address.
    xfer(64'h1000_0047, 0, 1'b0, -1, 15, 16, 32'hA000_0000, 1'b0, -1, dc, hs, ab);
    exp_line = fill(512'(0), 32'hA000_0000, 16);
    chk("t1_done_cyc", 512'(dc), 512'(18));
    chk("t1_data",     o_data, exp_line);
    chk("t1_err",      512'(o_error), 512'(0));
    chk("t1_araddr",   512'(AR_ADDR), 512'(64'h1000_0040));
    chk("t1_ar_stab",  512'(ab), 512'(0));
    chk("t1_ar_hs",    512'(hs), 512'(1));
    @(negedge clk);
    chk("t1_busy_low", 512'(o_busy), 512'(0));

    // AR_READY 3 cycles late, R_VALID every other cycle.
    xfer(64'h2000_0100, 3, 1'b1, -1, 15, 16, 32'hB000_0000, 1'b0, -1, dc, hs, ab);
    exp_line = fill(exp_line, 32'hB000_0000, 16);
    chk("t2_done_cyc", 512'(dc), 512'(36));
    chk("t2_data",     o_data, exp_line);
    chk("t2_err",      512'(o_error), 512'(0));
    chk("t2_ar_stab",  512'(ab), 512'(0));

    // SLVERR on beat 5 only.
    xfer(64'h0000_0000, 0, 1'b0, 5, 15, 16, 32'hC000_0000, 1'b0, -1, dc, hs, ab);
    exp_line = fill(exp_line, 32'hC000_0000, 16);
    chk("t3_done_cyc", 512'(dc), 512'(18));
    chk("t3_data",     o_data, exp_line);
    chk("t3_err",      512'(o_error), 512'(1));

    // Early R_LAST on beat 9: slices 10..15 keep the previous line.
    xfer(64'h0000_0040, 0, 1'b0, -1, 9, 10, 32'hD000_0000, 1'b0, -1, dc, hs, ab);
    exp_line = fill(exp_line, 32'hD000_0000, 10);
    chk("t4a_done_cyc", 512'(dc), 512'(12));
    chk("t4a_data",     o_data, exp_line);
    chk("t4a_err",      512'(o_error), 512'(1));

    // R_LAST only on beat 17: beats 16 and 17 dropped.
    xfer(64'h0000_0080, 0, 1'b0, -1, 17, 18, 32'hE000_0000, 1'b0, -1, dc, hs, ab);
    exp_line = fill(exp_line, 32'hE000_0000, 16);
    chk("t4b_done_cyc", 512'(dc), 512'(20));
    chk("t4b_data",     o_data, exp_line);
    chk("t4b_slice15",  512'(o_data[15*32 +: 32]), 512'(32'hE000_000F));
    chk("t4b_err",      512'(o_error), 512'(1));

    // Reset asserted while beat 7 is on the bus.
    xfer(64'h0000_00C0, 0, 1'b0, -1, 15, 16, 32'hF000_0000, 1'b0, 7, dc, hs, ab);
    chk("t5_rst_hit", 512'(dc), 512'(-1));
    @(negedge clk);
    chk("t5_busy",   512'(o_busy),   512'(0));
    chk("t5_done",   512'(o_done),   512'(0));
    chk("t5_err",    512'(o_error),  512'(0));
    chk("t5_arvld",  512'(AR_VALID), 512'(0));
    chk("t5_rrdy",   512'(R_READY),  512'(0));
    chk("t5_araddr", 512'(AR_ADDR),  512'(0));
    chk("t5_data",   o_data,         512'(0));
    arstn = 1'b1;
    @(negedge clk);
    chk("t5_leftover_rrdy", 512'(R_READY), 512'(0));
    chk("t5_leftover_data", o_data, 512'(0));
    R_VALID = 1'b0;

    // Clean transfer after reset with i_start held high while busy and in DONE.
    xfer(64'h3000_00C5, 0, 1'b0, -1, 15, 16, 32'h1234_0000, 1'b1, -1, dc, hs, ab);
    exp_line = fill(512'(0), 32'h1234_0000, 16);
    chk("t6_done_cyc", 512'(dc), 512'(18));
    chk("t6_data",     o_data, exp_line);
    chk("t6_err",      512'(o_error), 512'(0));
    chk("t6_ar_hs",    512'(hs), 512'(1));
    chk("t6_araddr",   512'(AR_ADDR), 512'(64'h3000_00C0));
    @(negedge clk);
    i_start = 1'b0;
    chk("t6_busy_c19",  512'(o_busy),   512'(0));
    chk("t6_arvld_c19", 512'(AR_VALID), 512'(0));
    @(negedge clk);
    chk("t6_busy_c20",  512'(o_busy),   512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
